// File: rtl/lfsr_epoch_sched.sv
// lfsr_epoch_sched
// Round-robin arbiter that lends one shared 16-bit LFSR to N_REQ stochastic
// number generator requesters. Each grant reseeds the LFSR with the winner's
// seed, steps it for a latched epoch length, then releases it.
//
// Ports:
//   TRIG        clock, rising edge
//   RESET       synchronous active-high reset
//   REQ         per-requester level request
//   SEED_IN     per-requester seeds, requester i at [i*SEED_W +: SEED_W]
//   LEN         epoch length in LFSR steps, sampled at grant
//   PAUSE       (only with LFSR_SCHED_PAUSE_EN) freezes stepping in RUN
//   GNT         registered one-hot grant
//   LFSR_LOAD   seed-load strobe (LOAD state)
//   LFSR_SEED   seed latched at grant, stable through the epoch
//   LFSR_STEP   LFSR shift enable
//   STEP_CNT    steps completed in the current epoch
//   EPOCH_DONE  one-cycle pulse after a full epoch
//   ABORT       one-cycle pulse when the grantee withdraws mid-epoch
//   BUSY        high whenever not IDLE
//
// Optional feature macro: LFSR_SCHED_PAUSE_EN (adds the PAUSE input).

module lfsr_epoch_sched #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned SEED_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic                    TRIG,
    input  logic                    RESET,
    input  logic [N_REQ-1:0]        REQ,
    input  logic [N_REQ*SEED_W-1:0] SEED_IN,
    input  logic [LEN_W-1:0]        LEN,
`ifdef LFSR_SCHED_PAUSE_EN
    input  logic                    PAUSE,
`endif
    output logic [N_REQ-1:0]        GNT,
    output logic                    LFSR_LOAD,
    output logic [SEED_W-1:0]       LFSR_SEED,
    output logic                    LFSR_STEP,
    output logic [LEN_W-1:0]        STEP_CNT,
    output logic                    EPOCH_DONE,
    output logic                    ABORT,
    output logic                    BUSY
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SEED_W-1:0]  seed_q, seed_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   idx_next;
    logic               withdraw;
    logic               pause;
    logic               load, step, done, abort;

`ifdef LFSR_SCHED_PAUSE_EN
    assign pause = PAUSE;
`else
    assign pause = 1'b0;
`endif

    // Circular search starting at PTR; candidate index is folded back
    // below N_REQ so non-power-of-two N_REQ works.
    always_comb begin : arb
        logic [IDX_W:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!win_vld && REQ[cand[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign idx_next = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
    assign withdraw = !REQ[idx_q];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        seed_d  = seed_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (win_vld) begin
                    gnt_d   = N_REQ'(1) << win_idx;
                    idx_d   = win_idx;
                    len_d   = LEN;
                    seed_d  = SEED_IN[win_idx*SEED_W +: SEED_W];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                load = 1'b1;
                if (withdraw) begin
                    abort   = 1'b1;
                    gnt_d   = '0;
                    ptr_d   = idx_next;
                    state_d = S_IDLE;
                end else begin
                    state_d = (len_q == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Withdrawal outranks PAUSE so an abort is never delayed.
                if (withdraw) begin
                    abort   = 1'b1;
                    gnt_d   = '0;
                    ptr_d   = idx_next;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (!pause) begin
                    step  = 1'b1;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                gnt_d   = '0;
                ptr_d   = idx_next;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge TRIG) begin
        if (RESET) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            seed_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            seed_q  <= seed_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    assign GNT        = gnt_q;
    assign LFSR_LOAD  = load;
    assign LFSR_SEED  = seed_q;
    assign LFSR_STEP  = step;
    assign STEP_CNT   = cnt_q;
    assign EPOCH_DONE = done;
    assign ABORT      = abort;
    assign BUSY       = (state_q != S_IDLE);

endmodule

// File: doc/lfsr_epoch_sched.md
Name: lfsr_epoch_sched

Overview:
Round-robin scheduler that shares one 16-bit LFSR random source among N_REQ stochastic-number-generator requesters.
Per grant it reseeds the shared LFSR with the winner's seed, then steps it for a programmable epoch length (bitstream length).
It signals epoch completion and returns the LFSR to the pool.
It sits between the SNG/neuron layer controllers and the shared LFSR instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
SEED_W, 16, LFSR seed width
LEN_W, 16, epoch length counter width

Ports:
TRIG  in  1  system clock, rising edge
RESET  in  1  synchronous, active-high reset
REQ  in  N_REQ  per-requester epoch request, level, held until EPOCH_DONE or withdrawn
SEED_IN  in  N_REQ*SEED_W  per-requester seed; requester i at bits [i*SEED_W +: SEED_W]
LEN  in  LEN_W  epoch length in LFSR steps; sampled at grant
GNT  out  N_REQ  one-hot grant, registered
LFSR_LOAD  out  1  one-cycle seed-load strobe to the LFSR
LFSR_SEED  out  SEED_W  seed presented with LFSR_LOAD; held stable during the epoch
LFSR_STEP  out  1  LFSR shift enable
STEP_CNT  out  LEN_W  steps completed in the current epoch
EPOCH_DONE  out  1  one-cycle pulse at the end of a full epoch
ABORT  out  1  one-cycle pulse when the grantee withdraws REQ mid-epoch
BUSY  out  1  high in any state except IDLE

Behaviour:
- Reset is synchronous, active-high.
- On RESET all outputs are 0, state is IDLE, and the round-robin pointer PTR is 0.
- RESET mid-epoch aborts immediately without an ABORT pulse.

State machine (IDLE, LOAD, RUN, DONE):
- IDLE:
  - If any REQ is high, select the first set REQ at or after PTR, circularly.
  - Register GNT one-hot, latch LEN into LEN_R, latch that requester's seed into LFSR_SEED, then go to LOAD.
  - If no REQ is high, stay in IDLE.
- LOAD (1 cycle):
  - LFSR_LOAD=1, STEP_CNT=0.
  - If LEN_R==0, go to DONE (zero-length epoch, no steps); otherwise go to RUN.
- RUN:
  - LFSR_STEP=1 every cycle; STEP_CNT increments by 1 each cycle.
  - When STEP_CNT reaches LEN_R-1 with STEP high, go to DONE. Exactly LEN_R step cycles occur.
- DONE (1 cycle):
  - EPOCH_DONE=1, GNT held, LFSR_STEP=0, STEP_CNT=LEN_R.
  - Next state is IDLE; GNT clears; PTR becomes grantee index+1, modulo N_REQ.

Timing and boundary rules:
- Latency from a REQ rise in IDLE to LFSR_LOAD is 1 cycle (GNT and LOAD assert together on the edge after REQ is sampled).
- Withdrawal: if the grantee's REQ drops in LOAD or RUN:
  - ABORT=1 for 1 cycle, GNT clears, LFSR_STEP=0.
  - Return to IDLE; PTR advances past the grantee.
  - No EPOCH_DONE.
- REQ changes from non-grantees during an epoch are ignored until IDLE.
- Changes to LEN or SEED_IN after grant have no effect.
- PTR wraps from N_REQ-1 to 0.
- IDLE always spends at least 1 cycle between epochs, so back-to-back epochs run IDLE, LOAD, RUN..., DONE, IDLE, LOAD.
- LEN = all-ones gives 2^LEN_W-1 steps; the counter must not overflow.

Optional Feature:
Macro: LFSR_SCHED_PAUSE_EN.
- When defined, an extra input PAUSE (1 bit) is added.
  - While PAUSE=1 in RUN: LFSR_STEP=0, STEP_CNT holds, and the state stays RUN.
  - PAUSE is ignored in the other states; withdrawal detection stays active during PAUSE.
- When undefined, the PAUSE port does not exist and RUN steps every cycle.

Test Plan:
1. Reset, then REQ=0001, LEN=5, SEED0=16'hACE1:
   - GNT=0001 and LFSR_LOAD=1 with LFSR_SEED=ACE1 on cycle 1.
   - Then exactly 5 LFSR_STEP cycles, STEP_CNT sequencing 1..5.
   - EPOCH_DONE pulses once; then BUSY=0.
2. REQ=1111 held, LEN=2:
   - Grants occur in order 0001, 0010, 0100, 1000, 0001, each epoch 1+2+1 cycles plus 1 IDLE.
   - Pointer wrap is verified.
3. LEN=0, REQ=0100:
   - LOAD, then DONE directly; zero LFSR_STEP cycles; EPOCH_DONE=1; STEP_CNT=0.
4. REQ=0010, LEN=10; drop REQ[1] after 3 steps:
   - ABORT pulses; no EPOCH_DONE; GNT=0 the next cycle.
   - A pending REQ[2] is granted next.
5. Assert RESET during RUN at STEP_CNT=4:
   - All outputs are 0 the next cycle and PTR=0.
   - With REQ=1000, the next grant is 1000.
6. With LFSR_SCHED_PAUSE_EN defined, LEN=6, PAUSE high for 3 cycles after step 2:
   - STEP_CNT holds at 2 and LFSR_STEP=0 during the pause.
   - Total epoch length is 1+6+3+1 cycles.
